// File: rtl/encrypt_stream.sv
// Purpose  : XORs each plaintext character with one RC4 keystream word and streams
//            the ciphertext out through a 2-entry buffer with a registered head.
// Latency  : 1 cycle from plaintext accept to ct_valid when the buffer is empty.
// Backpress: pt_ready drops when the keystream is not valid or the buffer is full;
//            ct_data holds steady while ct_valid & ~ct_ready.
// Ports    : clk/rst (async, active high); password/start/msg_len start a message;
//            ks_* handshake with the keystream generator; pt_* plaintext in
//            (valid/ready); ct_* ciphertext out (valid/ready); busy/done status.
module encrypt_stream #(
    parameter int n     = 7,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [n-1:0]     password,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic [n-1:0]     ks_key,
    output logic             ks_start,
    input  logic             ks_init_done,
    input  logic             ks_valid,
    input  logic [n-1:0]     ks_data,
    output logic             ks_req,
    input  logic [n-1:0]     pt_data,
    input  logic             pt_valid,
    output logic             pt_ready,
    output logic [n-1:0]     ct_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [n-1:0]     ks_key_q, ks_key_d;
    logic             ks_start_q, ks_start_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [n-1:0]     head_q, head_d;
    logic [n-1:0]     tail_q, tail_d;
    logic [1:0]       fill_q, fill_d;
    logic             ct_valid_q, ct_valid_d;

    logic             fifo_full;
    logic             accept;
    logic             pop;
    logic [n-1:0]     ct_word;

    always_comb begin
        state_d    = state_q;
        ks_key_d   = ks_key_q;
        ks_start_d = 1'b0;
        done_d     = 1'b0;
        len_d      = len_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;

        fifo_full = (fill_q == 2'd2);
        // Full blocks a push even when a pop happens in the same cycle.
        pt_ready  = (state_q == S_RUN) && ks_valid && !fifo_full;
        accept    = pt_valid && pt_ready;
        // A keystream word is popped only together with a plaintext character.
        ks_req    = accept;
        pop       = ct_valid_q && ct_ready;
        ct_word   = pt_data ^ ks_data;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (msg_len != '0) begin
                        ks_key_d   = password;
                        len_d      = msg_len;
                        cnt_d      = '0;
                        ks_start_d = 1'b1;
                        state_d    = S_INIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_INIT: begin
                if (ks_init_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    // len_q is never 0 here, so len_q-1 does not underflow.
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fill_q == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Head register is the visible output; tail only holds the second entry.
        case ({accept, pop})
            2'b10: begin
                if (fill_q == 2'd0) begin
                    head_d = ct_word;
                    fill_d = 2'd1;
                end else begin
                    tail_d = ct_word;
                    fill_d = 2'd2;
                end
            end
            2'b01: begin
                if (fill_q == 2'd2) begin
                    head_d = tail_q;
                    fill_d = 2'd1;
                end else begin
                    fill_d = 2'd0;
                end
            end
            2'b11: begin
                // Only reachable with exactly one entry: the new word replaces the head.
                head_d = ct_word;
                fill_d = 2'd1;
            end
            default: ;
        endcase

        ct_valid_d = (fill_d != 2'd0);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ks_key_q   <= '0;
            ks_start_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= 2'd0;
            ct_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ks_key_q   <= ks_key_d;
            ks_start_q <= ks_start_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            ct_valid_q <= ct_valid_d;
        end
    end

    assign ks_key   = ks_key_q;
    assign ks_start = ks_start_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign ct_data  = head_q;
    assign ct_valid = ct_valid_q;

endmodule

// File: tb/tb_encrypt_stream.sv
// Purpose  : self-checking bench for encrypt_stream against a queue-based model
//            (expected ciphertext list, buffer occupancy, decrypt round trip).
// Latency  : n/a.
// Backpress: sink/source/keystream availability driven directly or randomly.
module tb_encrypt_stream;
    localparam int N  = 7;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  password = '0;
    logic          start = 1'b0;
    logic [LW-1:0] msg_len = '0;
    logic [N-1:0]  ks_key;
    logic          ks_start;
    logic          ks_init_done = 1'b0;
    logic          ks_valid = 1'b0;
    logic [N-1:0]  ks_data = '0;
    logic          ks_req;
    logic [N-1:0]  pt_data = '0;
    logic          pt_valid = 1'b0;
    logic          pt_ready;
    logic [N-1:0]  ct_data;
    logic          ct_valid;
    logic          ct_ready = 1'b0;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    encrypt_stream #(.n(N), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .password(password), .start(start), .msg_len(msg_len),
        .ks_key(ks_key), .ks_start(ks_start), .ks_init_done(ks_init_done),
        .ks_valid(ks_valid), .ks_data(ks_data), .ks_req(ks_req),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] pt_src[$];
    logic [N-1:0] ks_arr[$];
    logic [N-1:0] exp_q[$];
    logic [N-1:0] ptref_q[$];
    logic [N-1:0] ks_used[$];

    int ks_idx    = 0;
    int init_cnt  = 0;
    bit init_done = 1'b0;
    bit ks_en     = 1'b1;
    bit sink_en   = 1'b1;
    bit src_en    = 1'b1;
    bit rand_mode = 1'b0;
    bit acc_seen  = 1'b0;
    bit req_seen  = 1'b0;
    bit kss_seen  = 1'b0;
    int mdl_cnt   = 0;
    int done_cnt  = 0;
    int kss_cnt   = 0;
    int acc_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        bit acc;
        bit pop;
        if (rst) begin
            mdl_cnt  = 0;
            acc_seen = 1'b0;
            req_seen = 1'b0;
            kss_seen = 1'b0;
        end else begin
            acc = pt_valid && pt_ready;
            pop = ct_valid && ct_ready;
            chk("ks_req_eq_accept", 32'(ks_req), 32'(acc));
            chk("ct_valid_occupancy", 32'(ct_valid), 32'(mdl_cnt != 0));
            if (mdl_cnt == 2) chk("pt_ready_when_full", 32'(pt_ready), 32'd0);
            if (!ks_valid) chk("pt_ready_without_ks", 32'(pt_ready), 32'd0);
            if (done || ks_start) chk("done_ks_start_excl", 32'(done && ks_start), 32'd0);
            if (acc) begin
                ks_used.push_back(ks_data);
                acc_cnt++;
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("ct_unexpected", 32'(ct_data), 32'hFFFF_FFFF);
                end else begin
                    chk("ct_data", 32'(ct_data), 32'(exp_q.pop_front()));
                end
                if (ks_used.size() > 0 && ptref_q.size() > 0) begin
                    chk("roundtrip_decrypt", 32'(ct_data ^ ks_used.pop_front()),
                        32'(ptref_q.pop_front()));
                end
            end
            mdl_cnt  = mdl_cnt + int'(acc) - int'(pop);
            done_cnt = done_cnt + int'(done);
            kss_cnt  = kss_cnt + int'(ks_start);
            acc_seen = acc;
            req_seen = ks_req;
            kss_seen = ks_start;
        end
    end

    // Source, sink and keystream generator models, updated just after each rising edge.
    task automatic drive_loop();
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ks_idx    = 0;
                init_done = 1'b0;
                init_cnt  = 0;
            end else begin
                if (acc_seen && pt_src.size() > 0) void'(pt_src.pop_front());
                if (req_seen) ks_idx++;
                if (kss_seen) begin
                    init_done = 1'b0;
                    init_cnt  = 3;
                    ks_idx    = 0;
                end else if (init_cnt > 0) begin
                    init_cnt--;
                    if (init_cnt == 0) init_done = 1'b1;
                end
            end
            ks_init_done = init_done;
            ks_valid = init_done && ks_en && (ks_idx < ks_arr.size()) &&
                       (!rand_mode || $urandom_range(3) != 0);
            ks_data  = (ks_idx < ks_arr.size()) ? ks_arr[ks_idx] : '0;
            pt_valid = src_en && (pt_src.size() > 0) && (!rand_mode || $urandom_range(3) != 0);
            pt_data  = (pt_src.size() > 0) ? pt_src[0] : '0;
            ct_ready = sink_en && (!rand_mode || $urandom_range(1) == 1);
        end
    endtask

    task automatic fill_random(input int len);
        pt_src.delete();
        ks_arr.delete();
        for (int i = 0; i < len; i++) begin
            pt_src.push_back(N'($urandom));
            ks_arr.push_back(N'($urandom));
        end
    endtask

    task automatic start_msg(input logic [N-1:0] pw, input int len);
        @(negedge clk);
        #1;
        exp_q.delete();
        ptref_q.delete();
        ks_used.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pt_src[i] ^ ks_arr[i]);
            ptref_q.push_back(pt_src[i]);
        end
        init_done    = 1'b0;
        ks_init_done = 1'b0;
        ks_valid     = 1'b0;
        ks_idx       = 0;
        password     = pw;
        msg_len      = LW'(len);
        start        = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 2000) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk({tag, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        chk({tag, "_all_ct_seen"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #2;
        chk({tag, "_done_single"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ks_key"}, 32'(ks_key), 32'd0);
        chk({tag, "_ks_start"}, 32'(ks_start), 32'd0);
        chk({tag, "_ct_data"}, 32'(ct_data), 32'd0);
        chk({tag, "_ct_valid"}, 32'(ct_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pt_ready"}, 32'(pt_ready), 32'd0);
        chk({tag, "_ks_req"}, 32'(ks_req), 32'd0);
    endtask

    initial begin
        int k0;
        int a0;
        int d0;
        int k;
        fork
            drive_loop();
        join_none

        // Power-on reset state.
        #1;
        chk_all_zero("por");
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Basic directed message.
        pt_src = '{7'h48, 7'h69};
        ks_arr = '{7'h15, 7'h33};
        k0 = kss_cnt;
        start_msg(7'h2A, 2);
        chk("basic_ks_key", 32'(ks_key), 32'h2A);
        chk("basic_exp0", 32'(exp_q[0]), 32'h5D);
        wait_done("basic");
        chk("basic_ks_start_once", 32'(kss_cnt - k0), 32'd1);

        // Backpressure: sink stalled, only two characters fit.
        sink_en = 1'b0;
        fill_random(4);
        a0 = acc_cnt;
        start_msg(N'($urandom), 4);
        repeat (15) @(negedge clk);
        #2;
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("bp_pt_ready", 32'(pt_ready), 32'd0);
        chk("bp_ct_valid", 32'(ct_valid), 32'd1);
        sink_en = 1'b1;
        wait_done("bp");

        // Keystream stall for three cycles while plaintext is offered.
        fill_random(6);
        a0 = acc_cnt;
        start_msg(N'($urandom), 6);
        k = 0;
        while (acc_cnt - a0 < 2 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("stall_reached_run", 32'(acc_cnt - a0 >= 2), 32'd1);
        ks_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("stall_ks_valid", 32'(ks_valid), 32'd0);
            chk("stall_pt_valid", 32'(pt_valid), 32'd1);
            chk("stall_pt_ready", 32'(pt_ready), 32'd0);
            chk("stall_ks_req", 32'(ks_req), 32'd0);
        end
        ks_en = 1'b1;
        wait_done("stall");

        // Zero-length message.
        k0 = kss_cnt;
        @(negedge clk);
        #1;
        msg_len = '0;
        start   = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2;
        chk("zero_done_clear", 32'(done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);
        chk("zero_no_ks_start", 32'(kss_cnt - k0), 32'd0);

        // Round trip of "HELLO" under random flow control.
        rand_mode = 1'b1;
        pt_src = '{7'h48, 7'h45, 7'h4C, 7'h4C, 7'h4F};
        ks_arr.delete();
        for (int i = 0; i < 5; i++) ks_arr.push_back(N'($urandom));
        start_msg(N'($urandom), 5);
        wait_done("hello");

        // Random messages.
        for (int m = 0; m < 6; m++) begin
            fill_random(int'($urandom_range(1, 8)));
            start_msg(N'($urandom), pt_src.size());
            wait_done("rand");
        end
        rand_mode = 1'b0;

        // Reset in the middle of a message with a full buffer.
        sink_en = 1'b0;
        fill_random(5);
        a0 = acc_cnt;
        start_msg(N'($urandom), 5);
        k = 0;
        while (acc_cnt - a0 < 2 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("midrst_buffer_full", 32'(ct_valid), 32'd1);
        d0 = done_cnt;
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        pt_src.delete();
        ks_arr.delete();
        exp_q.delete();
        ptref_q.delete();
        ks_used.delete();
        sink_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_ct_valid", 32'(ct_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);

        // Recovery after reset.
        pt_src = '{7'h48, 7'h69};
        ks_arr = '{7'h15, 7'h33};
        start_msg(7'h2A, 2);
        wait_done("recover");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
